// File: rtl/stack_pkg.sv
// Shared op/status encodings and capacity helper for the stack block.
package stack_pkg;

  typedef enum logic [1:0] {
    OpNone    = 2'd0,
    OpPush    = 2'd1,
    OpPop     = 2'd2,
    OpReplace = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StatNone      = 2'd0,
    StatEmpty     = 2'd1,
    StatOverflow  = 2'd2,
    StatUnderflow = 2'd3
  } status_e;

  function automatic int unsigned cap_of(input int unsigned depth);
    return (32'd1 << (depth + 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: synchronous write port, combinational read by index.
module stack_mem #(
  parameter int unsigned Width   = 8,
  parameter int unsigned Entries = 3,
  parameter int unsigned AddrW   = 2
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  localparam logic [AddrW-1:0] LastIdx = AddrW'(Entries - 1);

  logic [Width-1:0] mem_q [Entries];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Out-of-range reads only happen when the result is unused.
  assign rdata_o = (raddr_i <= LastIdx) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/stack.sv
// LIFO stack with registered tos/status. Define STACK_TOS_CLEAR_EN to also clear tos on reset.
module stack
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] tos,
  output logic [1:0]       status
);

  localparam int unsigned Cap  = cap_of(DEPTH);
  localparam int unsigned CntW = DEPTH + 1;
  localparam logic [CntW-1:0] CapCnt = CntW'(Cap);

  logic [CntW-1:0]  count_q = '0;
  logic [CntW-1:0]  count_d;
  logic [WIDTH-1:0] tos_q = '0;
  logic [WIDTH-1:0] tos_d;
  status_e          status_q = StatEmpty;
  status_e          status_d;

  logic             wr_en;
  logic [CntW-1:0]  wr_addr;
  logic [CntW-1:0]  rd_addr;
  logic [WIDTH-1:0] rd_data;

  always_comb begin
    count_d  = count_q;
    tos_d    = tos_q;
    status_d = (count_q == '0) ? StatEmpty : StatNone;
    wr_en    = 1'b0;
    wr_addr  = count_q;
    // Entry that becomes the top after a pop.
    rd_addr  = count_q - CntW'(2);
    case (op_e'(op))
      OpPush: begin
        if (count_q == CapCnt) begin
          status_d = StatOverflow;
        end else begin
          wr_en    = 1'b1;
          count_d  = count_q + CntW'(1);
          tos_d    = data;
          status_d = StatNone;
        end
      end
      OpPop: begin
        if (count_q == '0) begin
          status_d = StatUnderflow;
        end else if (count_q == CntW'(1)) begin
          count_d  = '0;
          status_d = StatEmpty;
        end else begin
          count_d  = count_q - CntW'(1);
          tos_d    = rd_data;
          status_d = StatNone;
        end
      end
      OpReplace: begin
        if (count_q == '0) begin
          status_d = StatUnderflow;
        end else begin
          wr_en    = 1'b1;
          wr_addr  = count_q - CntW'(1);
          tos_d    = data;
          status_d = StatNone;
        end
      end
      default: ;
    endcase
  end

  // An X on reset falls through to the normal-update branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      status_q <= StatEmpty;
`ifdef STACK_TOS_CLEAR_EN
      tos_q    <= '0;
`endif
    end else begin
      count_q  <= count_d;
      tos_q    <= tos_d;
      status_q <= status_d;
    end
  end

  stack_mem #(
    .Width  (WIDTH),
    .Entries(Cap),
    .AddrW  (CntW)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (wr_en & ~reset),
    .waddr_i(wr_addr),
    .wdata_i(data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  assign tos    = tos_q;
  assign status = status_q;

endmodule

// File: tb/tb_stack.sv
// Self-checking bench for stack: directed vector table, reset sequences, random vs queue model.
module tb_stack;

  localparam int unsigned W   = 8;
  localparam int unsigned CAP = 3;

  localparam logic [1:0] NONE = 2'd0, PUSH = 2'd1, POP = 2'd2, REPLACE = 2'd3;
  localparam logic [1:0] S_NONE = 2'd0, S_EMPTY = 2'd1, S_OVF = 2'd2, S_UNF = 2'd3;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   op;
  logic [W-1:0] data;
  logic [W-1:0] tos;
  logic [1:0]   status;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] data;
    logic [W-1:0] exp_tos;
    logic [1:0]   exp_status;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  int unsigned  mq[$];
  logic [W-1:0] m_tos;
  logic [1:0]   m_status;

  stack #(.WIDTH(W), .DEPTH(1)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .data  (data),
    .tos   (tos),
    .status(status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] exp_tos,
                       input logic [1:0] exp_status);
    total++;
    if (tos !== exp_tos || status !== exp_status) begin
      bad++;
      $display("FAIL %s: tos=%0d status=%0d, required tos=%0d status=%0d",
               name, tos, status, exp_tos, exp_status);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] o, input logic [W-1:0] d);
    @(negedge clk);
    reset = rst;
    op    = o;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic rst, input logic [1:0] o, input logic [W-1:0] d);
    if (rst) begin
      mq.delete();
      m_status = S_EMPTY;
`ifdef STACK_TOS_CLEAR_EN
      m_tos = '0;
`endif
    end else begin
      case (o)
        PUSH: if (mq.size() == CAP) m_status = S_OVF;
              else begin mq.push_back(d); m_tos = d; m_status = S_NONE; end
        POP: if (mq.size() == 0) m_status = S_UNF;
             else begin
               void'(mq.pop_back());
               if (mq.size() == 0) m_status = S_EMPTY;
               else begin m_tos = W'(mq[$]); m_status = S_NONE; end
             end
        REPLACE: if (mq.size() == 0) m_status = S_UNF;
                 else begin mq[mq.size()-1] = d; m_tos = d; m_status = S_NONE; end
        default: m_status = (mq.size() == 0) ? S_EMPTY : S_NONE;
      endcase
    end
  endtask

  function automatic vec_t mk(input logic [1:0] o, input logic [W-1:0] d,
                              input logic [W-1:0] t, input logic [1:0] s);
    vec_t v;
    v.op = o; v.data = d; v.exp_tos = t; v.exp_status = s;
    return v;
  endfunction

  logic [W-1:0] keep_tos;

  initial begin
    reset = 1'b0;
    op    = NONE;
    data  = '0;
    #1;
    check("powerup", 8'd0, S_EMPTY);

    vecs.push_back(mk(POP,     0, 0, S_UNF));
    vecs.push_back(mk(PUSH,    0, 0, S_NONE));
    vecs.push_back(mk(PUSH,    1, 1, S_NONE));
    vecs.push_back(mk(PUSH,    2, 2, S_NONE));
    vecs.push_back(mk(NONE,    0, 2, S_NONE));
    vecs.push_back(mk(PUSH,    3, 2, S_OVF));
    vecs.push_back(mk(PUSH,    4, 2, S_OVF));
    vecs.push_back(mk(NONE,    0, 2, S_NONE));
    vecs.push_back(mk(POP,     0, 1, S_NONE));
    vecs.push_back(mk(POP,     0, 0, S_NONE));
    vecs.push_back(mk(POP,     0, 0, S_EMPTY));
    vecs.push_back(mk(POP,     0, 0, S_UNF));
    vecs.push_back(mk(NONE,    0, 0, S_EMPTY));
    vecs.push_back(mk(REPLACE, 4, 0, S_UNF));
    vecs.push_back(mk(PUSH,    5, 5, S_NONE));
    vecs.push_back(mk(REPLACE, 6, 6, S_NONE));
    vecs.push_back(mk(NONE,    0, 6, S_NONE));

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].op, vecs[i].data);
      check($sformatf("vec%0d", i), vecs[i].exp_tos, vecs[i].exp_status);
    end

`ifdef STACK_TOS_CLEAR_EN
    keep_tos = 8'd0;
`else
    keep_tos = 8'd6;
`endif
    step(1'b1, NONE, 0);
    check("reset_pulse", keep_tos, S_EMPTY);
    step(1'b0, NONE, 0);
    check("after_reset", keep_tos, S_EMPTY);

    // Push to two entries, then reset and push collide: push must be dropped.
    step(1'b0, PUSH, 8'd7);
    check("push7", 8'd7, S_NONE);
    step(1'b0, PUSH, 8'd8);
    check("push8", 8'd8, S_NONE);
    step(1'b1, PUSH, 8'd9);
`ifdef STACK_TOS_CLEAR_EN
    keep_tos = 8'd0;
`else
    keep_tos = 8'd8;
`endif
    check("reset_push", keep_tos, S_EMPTY);
    step(1'b0, POP, 0);
    check("reset_push_cnt0", keep_tos, S_UNF);

    // Random phase: model picks up from a known empty state.
    mq.delete();
    m_tos    = keep_tos;
    m_status = S_UNF;
    for (int n = 0; n < 600; n++) begin
      logic         r;
      logic [1:0]   o;
      logic [W-1:0] d;
      r = ($urandom_range(0, 29) == 0);
      o = 2'($urandom_range(0, 3));
      d = W'($urandom);
      step(r, o, d);
      model(r, o, d);
      check($sformatf("rnd%0d", n), m_tos, m_status);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack.md
STACK -- requirements
Module: stack

Interface
REQ-001 Parameter WIDTH, default 8: data and tos width in bits.
REQ-002 Parameter DEPTH, default 1: capacity exponent; capacity CAP = 2^(DEPTH+1) - 1 entries (CAP = 3 at default).
REQ-003 One clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 op  input  2  operation code: NONE, PUSH, POP or REPLACE.
REQ-007 data  input  WIDTH  operand for PUSH and REPLACE.
REQ-008 tos  output  WIDTH  registered top-of-stack value.
REQ-009 status  output  2  registered status code: NONE, EMPTY, OVERFLOW or UNDERFLOW.

Function
REQ-010 Encodings SHALL be: op NONE=0, PUSH=1, POP=2, REPLACE=3; status NONE=0, EMPTY=1, OVERFLOW=2, UNDERFLOW=3.
REQ-011 State SHALL be an entry count (0..CAP) plus CAP x WIDTH storage; op SHALL be sampled every rising edge; tos and status SHALL update at that same edge (1-cycle latency, no handshake).
REQ-012 PUSH with count<CAP: store data at the top, count+1, tos<=data, status<=NONE, including when count reaches CAP (no "full" status).
REQ-013 PUSH with count==CAP: storage, count and tos unchanged; status<=OVERFLOW.
REQ-014 POP with count>=2: count-1; tos<=new top entry; status<=NONE.
REQ-015 POP with count==1: count<=0; tos unchanged; status<=EMPTY.
REQ-016 POP with count==0: no state change; tos unchanged; status<=UNDERFLOW.
REQ-017 REPLACE with count>=1: overwrite the top entry with data; tos<=data; count unchanged; status<=NONE.
REQ-018 REPLACE with count==0: no state change; tos unchanged; status<=UNDERFLOW.
REQ-019 NONE: storage, count and tos unchanged; status<=EMPTY if count==0, else NONE, which clears any earlier OVERFLOW/UNDERFLOW.
REQ-020 Error statuses SHALL last exactly one cycle unless the failing op repeats.

Reset
REQ-021 reset high at a rising edge: count<=0, status<=EMPTY; reset SHALL take priority over op.
REQ-022 Reset SHALL leave tos and storage contents unchanged unless STACK_TOS_CLEAR_EN is defined.
REQ-023 Power-up (initial) values SHALL be count=0, status=EMPTY, tos=0, so status reads EMPTY before any reset.
REQ-024 An unknown reset level SHALL be treated as deasserted.

Configuration
REQ-025 Macro STACK_TOS_CLEAR_EN: when defined, reset also forces tos<=0.
REQ-026 When STACK_TOS_CLEAR_EN is undefined, tos keeps its value through reset (default build).

Structure
REQ-027 Shared header/package stack.vh SHALL hold the op and status constants (NONE, PUSH, POP, REPLACE, EMPTY, OVERFLOW, UNDERFLOW).
REQ-028 Storage SHALL be a single sub-module stack_mem: CAP x WIDTH synchronous write, combinational read by index.
REQ-029 The control logic (count, tos, status) SHALL reside in stack.

Verification
REQ-030 Power-up, then POP -> status EMPTY before the first edge, then UNDERFLOW after the POP edge.
REQ-031 PUSH 0, 1, 2, each checked one edge later -> tos 0, 1, 2 and status NONE each time; a following NONE op -> tos 2, status NONE.
REQ-032 Stack full, PUSH 3 -> status OVERFLOW, tos 2; POP, POP, POP -> (NONE, tos 1), (NONE, tos 0), (EMPTY).
REQ-033 Empty stack, REPLACE 4 -> UNDERFLOW; PUSH 5 -> tos 5, NONE; REPLACE 6 -> tos 6, NONE.
REQ-034 With one entry holding 6, pulse reset for one cycle -> status EMPTY, tos 6 (default build) or tos 0 (STACK_TOS_CLEAR_EN defined).
REQ-035 With reset and PUSH on the same edge -> status EMPTY and count 0; the push is ignored.
